// File: rtl/ariane_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ariane_pkg
//  Description : Core-side types shared with the functional units
//  Revision    : 1.0 - initial release
// ============================================================================
package ariane_pkg;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

endpackage
`default_nettype wire

// File: rtl/cvxif_buffered_fu_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cvxif_buffered_fu_pkg
//  Description : Sizing of the illegal-report FIFO entry.
//                CVXIF_ILL_TVAL_EN adds the 32-bit instruction to each entry.
//  Revision    : 1.0 - initial release
// ============================================================================
package cvxif_buffered_fu_pkg;

`ifdef CVXIF_ILL_TVAL_EN
  localparam int unsigned ILL_INSTR_BITS = 32;
`else
  localparam int unsigned ILL_INSTR_BITS = 0;
`endif

  // Entry holds the transaction id, plus the instruction when tval is kept.
  function automatic int unsigned ill_entry_width(input int unsigned id_bits);
    return id_bits + ILL_INSTR_BITS;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cvxif_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : cvxif_pkg
//  Description : Core-V eXtension interface request/response types
//  Revision    : 1.0 - initial release
// ============================================================================
package cvxif_pkg;

  localparam int unsigned X_NUM_RS    = 3;
  localparam int unsigned X_ID_WIDTH  = 3;
  localparam int unsigned X_RFR_WIDTH = 64;
  localparam int unsigned X_RFW_WIDTH = 64;

  typedef struct packed {
    logic [31:0]                          instr;
    logic [X_ID_WIDTH-1:0]                id;
    logic [X_NUM_RS-1:0][X_RFR_WIDTH-1:0] rs;
    logic [X_NUM_RS-1:0]                  rs_valid;
  } x_issue_req_t;

  typedef struct packed {
    logic accept;
    logic writeback;
  } x_issue_resp_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0] id;
    logic                  x_kill;
  } x_commit_t;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    logic [X_RFW_WIDTH-1:0] data;
    logic [4:0]             rd;
    logic                   we;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  typedef struct packed {
    logic         x_issue_valid;
    x_issue_req_t x_issue_req;
    logic         x_commit_valid;
    x_commit_t    x_commit;
    logic         x_result_ready;
  } cvxif_req_t;

  typedef struct packed {
    logic          x_issue_ready;
    x_issue_resp_t x_issue_resp;
    logic          x_result_valid;
    x_result_t     x_result;
  } cvxif_resp_t;

endpackage
`default_nettype wire

// File: rtl/riscv.sv
`default_nettype none
// ============================================================================
//  Package     : riscv
//  Description : RISC-V architectural constants used by the writeback path
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv;

  localparam logic [63:0] ILLEGAL_INSTR = 64'd2;

endpackage
`default_nettype wire

// File: rtl/cvxif_ill_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : cvxif_ill_fifo
//  Description : Small FIFO of pending illegal-instruction reports with
//                synchronous flush and occupancy count.
//  Revision    : 1.0 - initial release
// ============================================================================
module cvxif_ill_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]            count_q, count_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic                        push_ok, pop_ok;

  // Never overfill or underflow, whatever the caller asks for.
  assign push_ok = push_i & (count_q != CNT_W'(DEPTH));
  assign pop_ok  = pop_i & (count_q != '0);

  // Next-state: flush wins; pointers wrap naturally since DEPTH is a power of 2.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = data_i;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  // State registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/cvxif_buffered_fu.sv
`default_nettype none
// ============================================================================
//  Module      : cvxif_buffered_fu
//  Description : CV-X-IF functional unit. Forwards issues to the coprocessor,
//                queues rejected issues and reports them as illegal
//                instructions when the result bus is idle.
//                Define CVXIF_ILL_TVAL_EN to report the instruction in tval.
//  Revision    : 1.0 - initial release
// ============================================================================
module cvxif_buffered_fu
  import cvxif_pkg::*;
  import ariane_pkg::*;
  import cvxif_buffered_fu_pkg::*;
#(
  parameter int unsigned NrRs        = 2,
  parameter int unsigned IllDepth    = 4,
  parameter int unsigned TransIdBits = 3,
  parameter int unsigned XLEN        = 64
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      flush_i,
  input  logic                      x_valid_i,
  output logic                      x_ready_o,
  input  logic [31:0]               x_off_instr_i,
  input  logic [TransIdBits-1:0]    trans_id_i,
  input  logic [XLEN-1:0]           operand_a_i,
  input  logic [XLEN-1:0]           operand_b_i,
  input  logic [XLEN-1:0]           operand_c_i,
  output logic [TransIdBits-1:0]    x_trans_id_o,
  output logic [XLEN-1:0]           x_result_o,
  output exception_t                x_exception_o,
  output logic                      x_valid_o,
  output logic                      x_we_o,
  output logic [$clog2(IllDepth):0] ill_pending_o,
  output cvxif_req_t                cvxif_req_o,
  input  cvxif_resp_t               cvxif_resp_i
);

  localparam int unsigned ILL_W = ill_entry_width(TransIdBits);
  localparam int unsigned CNT_W = $clog2(IllDepth) + 1;

  logic [CNT_W-1:0]       ill_count;
  logic                   ill_full;
  logic                   issue_valid;
  logic                   ill_push, ill_pop;
  logic [ILL_W-1:0]       push_data, head_data;
  logic [TransIdBits-1:0] head_id;
  logic [63:0]            head_tval;
  logic [X_RFR_WIDTH-1:0] rs2_val;
  logic                   unused_resp;

  assign ill_full    = (ill_count == CNT_W'(IllDepth));
  assign issue_valid = x_valid_i & ~ill_full & ~flush_i;
  assign x_ready_o   = cvxif_resp_i.x_issue_ready & ~ill_full & ~flush_i;

  // A rejected issue becomes a queued illegal report; a flush drops it.
  assign ill_push = issue_valid & cvxif_resp_i.x_issue_ready & ~cvxif_resp_i.x_issue_resp.accept;
  // Illegal reports only use writeback slots the coprocessor leaves empty.
  assign ill_pop  = ~cvxif_resp_i.x_result_valid & (ill_count != '0) & ~flush_i;

`ifdef CVXIF_ILL_TVAL_EN
  assign push_data = {x_off_instr_i, trans_id_i};
  assign head_tval = 64'(head_data[ILL_W-1 -: 32]);
`else
  assign push_data = trans_id_i;
  assign head_tval = '0;
`endif
  assign head_id = head_data[TransIdBits-1:0];

  // Third source operand exists only in the three-operand configuration.
  if (NrRs == 3) begin : g_rs3
    assign rs2_val = X_RFR_WIDTH'(operand_c_i);
  end else begin : g_rs2
    logic unused_operand_c;
    assign unused_operand_c = ^operand_c_i;
    assign rs2_val          = '0;
  end

  // Fields of the response not consumed by this unit (rd, writeback, ...).
  assign unused_resp = ^cvxif_resp_i;

  cvxif_ill_fifo #(
    .DEPTH (IllDepth),
    .WIDTH (ILL_W)
  ) u_ill_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (ill_push),
    .data_i  (push_data),
    .pop_i   (ill_pop),
    .data_o  (head_data),
    .count_o (ill_count)
  );

  // Issue and commit requests; payload is zero whenever no issue is offered.
  always_comb begin
    cvxif_req_o                      = '0;
    cvxif_req_o.x_result_ready       = 1'b1;
    cvxif_req_o.x_issue_req.rs_valid = X_NUM_RS'({NrRs{1'b1}});
    if (issue_valid) begin
      cvxif_req_o.x_issue_valid        = 1'b1;
      cvxif_req_o.x_issue_req.instr    = x_off_instr_i;
      cvxif_req_o.x_issue_req.id       = X_ID_WIDTH'(trans_id_i);
      cvxif_req_o.x_issue_req.rs[0]    = X_RFR_WIDTH'(operand_a_i);
      cvxif_req_o.x_issue_req.rs[1]    = X_RFR_WIDTH'(operand_b_i);
      cvxif_req_o.x_issue_req.rs[2]    = rs2_val;
      cvxif_req_o.x_commit_valid       = 1'b1;
      cvxif_req_o.x_commit.id          = X_ID_WIDTH'(trans_id_i);
    end
  end

  // Writeback mux: coprocessor result has priority over queued illegal reports.
  always_comb begin
    x_valid_o     = 1'b0;
    x_trans_id_o  = '0;
    x_result_o    = '0;
    x_we_o        = 1'b0;
    x_exception_o = '0;
    if (cvxif_resp_i.x_result_valid) begin
      x_valid_o           = 1'b1;
      x_trans_id_o        = TransIdBits'(cvxif_resp_i.x_result.id);
      x_result_o          = cvxif_resp_i.x_result.data[XLEN-1:0];
      x_we_o              = cvxif_resp_i.x_result.we;
      x_exception_o.cause = 64'(cvxif_resp_i.x_result.exccode);
      x_exception_o.valid = cvxif_resp_i.x_result.exc;
    end else if (ill_pop) begin
      x_valid_o           = 1'b1;
      x_trans_id_o        = head_id;
      x_exception_o.cause = riscv::ILLEGAL_INSTR;
      x_exception_o.tval  = head_tval;
      x_exception_o.valid = 1'b1;
    end
  end

  assign ill_pending_o = ill_count;

endmodule
`default_nettype wire

// File: tb/tb_cvxif_buffered_fu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cvxif_buffered_fu
//  Description : Self-checking bench for cvxif_buffered_fu (queue model plus
//                directed scenarios). Honours CVXIF_ILL_TVAL_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cvxif_buffered_fu;
  import cvxif_pkg::*;
  import ariane_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        x_valid_i;
  logic [31:0] instr;
  logic [2:0]  tid;
  logic [63:0] opa, opb, opc;
  cvxif_resp_t resp;

  logic        x_ready_o, x_valid_o, x_we_o;
  logic [2:0]  x_trans_id_o;
  logic [63:0] x_result_o;
  exception_t  x_exception_o;
  logic [2:0]  ill_pending_o;
  cvxif_req_t  req_o;

  logic        x_ready3, x_valid3, x_we3;
  logic [2:0]  x_trans_id3;
  logic [63:0] x_result3;
  exception_t  x_exception3;
  logic [2:0]  ill_pending3;
  cvxif_req_t  req3;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  cvxif_buffered_fu #(.NrRs(2), .IllDepth(DEPTH), .TransIdBits(3), .XLEN(64)) u_dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .x_valid_i(x_valid_i),
    .x_ready_o(x_ready_o), .x_off_instr_i(instr), .trans_id_i(tid),
    .operand_a_i(opa), .operand_b_i(opb), .operand_c_i(opc),
    .x_trans_id_o(x_trans_id_o), .x_result_o(x_result_o), .x_exception_o(x_exception_o),
    .x_valid_o(x_valid_o), .x_we_o(x_we_o), .ill_pending_o(ill_pending_o),
    .cvxif_req_o(req_o), .cvxif_resp_i(resp)
  );

  cvxif_buffered_fu #(.NrRs(3), .IllDepth(DEPTH), .TransIdBits(3), .XLEN(64)) u_dut3 (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .x_valid_i(x_valid_i),
    .x_ready_o(x_ready3), .x_off_instr_i(instr), .trans_id_i(tid),
    .operand_a_i(opa), .operand_b_i(opb), .operand_c_i(opc),
    .x_trans_id_o(x_trans_id3), .x_result_o(x_result3), .x_exception_o(x_exception3),
    .x_valid_o(x_valid3), .x_we_o(x_we3), .ill_pending_o(ill_pending3),
    .cvxif_req_o(req3), .cvxif_resp_i(resp)
  );

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model: queue of rejected issues ----------------
  typedef struct {
    logic [2:0]  id;
    logic [31:0] instr;
  } ent_t;
  ent_t q[$];

  logic        m_full, m_ready, m_ivalid, m_pop;
  logic        e_valid, e_we;
  logic [2:0]  e_id;
  logic [63:0] e_data;
  exception_t  e_exc;

  always @(negedge clk_i) begin
    if (!rst_ni) q.delete();
    m_full   = (q.size() == DEPTH);
    m_ready  = resp.x_issue_ready && !m_full && !flush_i;
    m_ivalid = x_valid_i && !m_full && !flush_i;
    m_pop    = !resp.x_result_valid && (q.size() > 0) && !flush_i;
    e_valid = 0; e_we = 0; e_id = 0; e_data = 0; e_exc = '0;
    if (resp.x_result_valid) begin
      e_valid = 1; e_id = resp.x_result.id; e_data = resp.x_result.data;
      e_we = resp.x_result.we;
      e_exc.cause = {58'd0, resp.x_result.exccode};
      e_exc.valid = resp.x_result.exc;
    end else if (m_pop) begin
      e_valid = 1; e_id = q[0].id;
      e_exc.cause = 64'd2;
      e_exc.valid = 1;
`ifdef CVXIF_ILL_TVAL_EN
      e_exc.tval = {32'd0, q[0].instr};
`endif
    end
    chk("ready",       {255'd0, x_ready_o}, {255'd0, m_ready});
    chk("pending",     {253'd0, ill_pending_o}, 256'(q.size()));
    chk("wb_valid",    {255'd0, x_valid_o}, {255'd0, e_valid});
    chk("wb_id",       {253'd0, x_trans_id_o}, {253'd0, e_id});
    chk("wb_data",     {192'd0, x_result_o}, {192'd0, e_data});
    chk("wb_we",       {255'd0, x_we_o}, {255'd0, e_we});
    chk("wb_exc",      {127'd0, x_exception_o}, {127'd0, e_exc});
    chk("issue_valid", {255'd0, req_o.x_issue_valid}, {255'd0, m_ivalid});
    chk("issue_instr", {224'd0, req_o.x_issue_req.instr}, m_ivalid ? {224'd0, instr} : 256'd0);
    chk("issue_id",    {253'd0, req_o.x_issue_req.id}, m_ivalid ? {253'd0, tid} : 256'd0);
    chk("issue_rs",    {64'd0, req_o.x_issue_req.rs}, m_ivalid ? {128'd0, opb, opa} : 256'd0);
    chk("rs_valid",    {253'd0, req_o.x_issue_req.rs_valid}, 256'd3);
    chk("commit",      {251'd0, req_o.x_commit_valid, req_o.x_commit.id, req_o.x_commit.x_kill},
                       m_ivalid ? {251'd0, 1'b1, tid, 1'b0} : 256'd0);
    chk("result_rdy",  {255'd0, req_o.x_result_ready}, 256'd1);
    if (rst_ni) begin
      if (flush_i) q.delete();
      else begin
        if (m_pop) q.delete(0);
        if (m_ivalid && resp.x_issue_ready && !resp.x_issue_resp.accept)
          q.push_back('{id: tid, instr: instr});
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk_i);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk_i);
    #1;
  endtask

  task automatic idle();
    flush_i = 0; x_valid_i = 0; instr = 0; tid = 0;
    opa = 0; opb = 0; opc = 0;
    resp = '0;
    resp.x_issue_ready = 1'b1;
  endtask

  logic [63:0] exp_tval;
  logic [11:0] vpat, rpat;

  initial begin
`ifdef CVXIF_ILL_TVAL_EN
    exp_tval = 64'h0000_000B;
`else
    exp_tval = 64'd0;
`endif
    rst_ni = 0;
    idle();
    cyc(); cyc();
    at_neg();
    chk("rst_pending", {253'd0, ill_pending_o}, 256'd0);
    chk("rst_valid",   {255'd0, x_valid_o}, 256'd0);
    chk("rst_ready",   {255'd0, x_ready_o}, 256'd1);
    cyc();
    rst_ni = 1;
    cyc();

    // Rejected issue id 2 -> illegal report next cycle; operand routing.
    x_valid_i = 1; instr = 32'h0000_000B; tid = 3'd2;
    opa = 64'h11; opb = 64'h22; opc = 64'h33;
    at_neg();
    chk("lit_issue_valid", {255'd0, req_o.x_issue_valid}, 256'd1);
    chk("lit_rs3",         {64'd0, req3.x_issue_req.rs}, {64'd0, 64'h33, 64'h22, 64'h11});
    chk("lit_rsv3",        {253'd0, req3.x_issue_req.rs_valid}, 256'b111);
    chk("lit_rsv2",        {253'd0, req_o.x_issue_req.rs_valid}, 256'b011);
    chk("lit_rs2_zero",    {192'd0, req_o.x_issue_req.rs[2]}, 256'd0);
    chk("lit_ill_silent",  {255'd0, x_valid_o}, 256'd0);
    cyc();
    idle();
    at_neg();
    chk("lit_ill_valid", {255'd0, x_valid_o}, 256'd1);
    chk("lit_ill_id",    {253'd0, x_trans_id_o}, 256'd2);
    chk("lit_ill_cause", {192'd0, x_exception_o.cause}, 256'd2);
    chk("lit_ill_exc",   {255'd0, x_exception_o.valid}, 256'd1);
    chk("lit_ill_tval",  {192'd0, x_exception_o.tval}, {192'd0, exp_tval});
    cyc();
    at_neg();
    chk("lit_drained", {253'd0, ill_pending_o}, 256'd0);
    cyc();

    // Fill the queue while the result bus is busy.
    resp.x_result_valid = 1; resp.x_result.id = 3'd7;
    resp.x_result.data = 64'hDEAD_BEEF; resp.x_result.we = 1;
    for (int k = 1; k <= 4; k++) begin
      x_valid_i = 1; tid = 3'(k); instr = 32'h100 + 32'(k);
      cyc();
    end
    tid = 3'd5;
    at_neg();
    chk("lit_full_pending", {253'd0, ill_pending_o}, 256'd4);
    chk("lit_full_ready",   {255'd0, x_ready_o}, 256'd0);
    chk("lit_full_ivalid",  {255'd0, req_o.x_issue_valid}, 256'd0);
    cyc();

    // Release the bus: four illegal writebacks in order.
    idle();
    for (int k = 1; k <= 4; k++) begin
      at_neg();
      chk("lit_drain_valid", {255'd0, x_valid_o}, 256'd1);
      chk("lit_drain_id",    {253'd0, x_trans_id_o}, 256'(k));
      cyc();
    end
    at_neg();
    chk("lit_empty", {253'd0, ill_pending_o}, 256'd0);
    cyc();

    // Same-cycle reject and coprocessor result (count 1).
    resp.x_result_valid = 1; resp.x_result.id = 3'd5;
    resp.x_result.data = 64'hABC; resp.x_result.we = 1;
    x_valid_i = 1; tid = 3'd3; instr = 32'h33;
    cyc();
    tid = 3'd6; instr = 32'h66;
    at_neg();
    chk("lit_pass_id",   {253'd0, x_trans_id_o}, 256'd5);
    chk("lit_pass_data", {192'd0, x_result_o}, 256'hABC);
    chk("lit_pass_cnt",  {253'd0, ill_pending_o}, 256'd1);
    cyc();
    x_valid_i = 0;
    at_neg();
    chk("lit_cnt2", {253'd0, ill_pending_o}, 256'd2);
    cyc();

    // Third entry, then flush with a rejected issue pending.
    x_valid_i = 1; tid = 3'd1; instr = 32'h77;
    resp.x_result.exc = 1; resp.x_result.exccode = 6'd5;
    at_neg();
    chk("lit_exc_cause", {192'd0, x_exception_o.cause}, 256'd5);
    cyc();
    resp.x_result_valid = 0; resp.x_result.exc = 0; resp.x_result.exccode = 0;
    flush_i = 1; tid = 3'd2;
    at_neg();
    chk("lit_fl_cnt",   {253'd0, ill_pending_o}, 256'd3);
    chk("lit_fl_valid", {255'd0, x_valid_o}, 256'd0);
    chk("lit_fl_ready", {255'd0, x_ready_o}, 256'd0);
    cyc();
    idle();
    at_neg();
    chk("lit_fl_after", {253'd0, ill_pending_o}, 256'd0);
    chk("lit_fl_nowb",  {255'd0, x_valid_o}, 256'd0);
    cyc();

    // Accepted issue is not queued.
    x_valid_i = 1; tid = 3'd4; resp.x_issue_resp.accept = 1;
    cyc();
    idle();
    at_neg();
    chk("lit_accept", {253'd0, ill_pending_o}, 256'd0);
    cyc();

    // Reset mid-operation drops queued reports.
    resp.x_result_valid = 1;
    x_valid_i = 1; tid = 3'd3; cyc();
    tid = 3'd4; cyc();
    idle();
    rst_ni = 0;
    at_neg();
    chk("lit_rst_cnt",   {253'd0, ill_pending_o}, 256'd0);
    chk("lit_rst_valid", {255'd0, x_valid_o}, 256'd0);
    cyc();
    rst_ni = 1;
    cyc();

    // Interleaved push/pop pattern crossing the pointer wrap.
    vpat = 12'b1011_1110_1101;
    rpat = 12'b0100_0111_0010;
    for (int i = 0; i < 12; i++) begin
      x_valid_i = vpat[i]; tid = 3'(i); instr = 32'h200 + 32'(i);
      opa = 64'(i) * 3; opb = 64'(i) * 5;
      resp.x_result_valid = rpat[i]; resp.x_result.id = 3'(7 - i);
      resp.x_result.data = 64'h1000 + 64'(i); resp.x_result.we = i[0];
      cyc();
    end
    idle();
    repeat (6) cyc();
    at_neg();
    chk("lit_final", {253'd0, ill_pending_o}, 256'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
